ewrapper_tx_word_packer: RTL and testbench

- Upstream neighbour of the eLink TX serializer, in the slow core-clock domain.
- Accepts 8-byte transmit words (data plus per-byte frame flags) over a valid/ready interface and buffers them in a small FIFO.
- Transposes each word into the 72-bit channel-major layout the serializer expects: 9 channels × 8 time slots.
- Drives an idle word whenever no data is available, and flags underruns that occur in the middle of a frame.

---
 rtl/ewrapper_tx_word_packer.sv | 113 +++++++++++
 tb/tb_ewrapper_tx_word_packer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ewrapper_tx_word_packer.sv
// Core-clock word packer ahead of the eLink TX serializer: buffers 8-byte words,
// transposes them into the 9-channel x 8-slot layout, and tracks mid-frame underruns.
module ewrapper_tx_word_packer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              TX_ENABLE,
    input  logic [63:0]       DATA_IN,
    input  logic [7:0]        FRAME_IN,
    input  logic              IN_VALID,
    output logic              IN_READY,
    output logic [71:0]       DATA_OUT_TO_IO,
    output logic              FIFO_EMPTY,
    output logic              UNDERRUN,
    output logic [CNT_W-1:0]  UNDERRUN_CNT,
    input  logic              UNDERRUN_CLR
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Entries hold the raw word as {FRAME_IN, DATA_IN}; transposition happens on read.
    logic [71:0]       mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_next;
    logic              last_frame;
    logic              wr_en;
    logic              rd_en;
    logic              underrun_evt;

    // Handshake: a word transfers on a rising edge where IN_VALID and IN_READY are
    // both 1; the source must hold DATA_IN/FRAME_IN stable while IN_READY is 0.
    assign wr_en        = IN_VALID & IN_READY;
    assign rd_en        = TX_ENABLE & ~FIFO_EMPTY;
    assign underrun_evt = TX_ENABLE & FIFO_EMPTY & last_frame;

    always_comb begin
        count_next = count;
        if (wr_en && !rd_en) begin
            count_next = count + 1'b1;
        end else if (rd_en && !wr_en) begin
            count_next = count - 1'b1;
        end
    end

    // Channel c carries bit c of every byte, slot 0 in the MSB; channel 8 is frame.
    function automatic logic [71:0] transpose(input logic [71:0] raw);
        logic [71:0] t;
        t = '0;
        for (int s = 0; s < 8; s++) begin
            for (int b = 0; b < 8; b++) begin
                t[8*b + 7 - s] = raw[8*s + b];
            end
            t[71 - s] = raw[64 + s];
        end
        return t;
    endfunction

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_ptr] <= {FRAME_IN, DATA_IN};
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            IN_READY       <= 1'b0;
            FIFO_EMPTY     <= 1'b1;
            DATA_OUT_TO_IO <= '0;
            last_frame     <= 1'b0;
            UNDERRUN       <= 1'b0;
            UNDERRUN_CNT   <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count      <= count_next;
            IN_READY   <= (count_next != FULL_CNT);
            FIFO_EMPTY <= (count_next == '0);

            // An idle cycle always closes the frame, so one starvation counts once.
            if (rd_en) begin
                DATA_OUT_TO_IO <= transpose(mem[rd_ptr]);
                last_frame     <= mem[rd_ptr][71];
            end else begin
                DATA_OUT_TO_IO <= '0;
                last_frame     <= 1'b0;
            end

            if (UNDERRUN_CLR) begin
                UNDERRUN     <= 1'b0;
                UNDERRUN_CNT <= '0;
            end else if (underrun_evt) begin
                UNDERRUN <= 1'b1;
                if (UNDERRUN_CNT != {CNT_W{1'b1}}) begin
                    UNDERRUN_CNT <= UNDERRUN_CNT + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ewrapper_tx_word_packer.sv
// Bench for ewrapper_tx_word_packer: queue-based model checked every cycle, plus
// hand-computed expectations for transpose, backpressure, underrun, saturation and reset.
module tb_ewrapper_tx_word_packer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_en;
    logic        in_valid;
    logic        und_clr;
    logic [63:0] data_in;
    logic [7:0]  frame_in;

    logic        in_ready, fifo_empty, underrun;
    logic [71:0] dout;
    logic [7:0]  cnt;
    logic        in_ready2, fifo_empty2, underrun2;
    logic [71:0] dout2;
    logic [1:0]  cnt2;

    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    ewrapper_tx_word_packer #(.DEPTH(DEPTH), .CNT_W(8)) dut (
        .CLK(clk), .RESET(rst), .TX_ENABLE(tx_en), .DATA_IN(data_in),
        .FRAME_IN(frame_in), .IN_VALID(in_valid), .IN_READY(in_ready),
        .DATA_OUT_TO_IO(dout), .FIFO_EMPTY(fifo_empty), .UNDERRUN(underrun),
        .UNDERRUN_CNT(cnt), .UNDERRUN_CLR(und_clr)
    );

    ewrapper_tx_word_packer #(.DEPTH(DEPTH), .CNT_W(2)) dut2 (
        .CLK(clk), .RESET(rst), .TX_ENABLE(tx_en), .DATA_IN(data_in),
        .FRAME_IN(frame_in), .IN_VALID(in_valid), .IN_READY(in_ready2),
        .DATA_OUT_TO_IO(dout2), .FIFO_EMPTY(fifo_empty2), .UNDERRUN(underrun2),
        .UNDERRUN_CNT(cnt2), .UNDERRUN_CLR(und_clr)
    );

    // ---------------- model ----------------
    // Serializer word: for each channel, bit (7-s) is that channel's bit in slot s.
    function automatic logic [71:0] pack(input logic [71:0] raw);
        logic [71:0] w;
        logic [7:0]  ch;
        logic [7:0]  slot_byte;
        w = '0;
        for (int c = 0; c < 9; c++) begin
            ch = '0;
            for (int s = 0; s < 8; s++) begin
                slot_byte = raw[8*s +: 8];
                ch[7 - s] = (c < 8) ? slot_byte[c] : raw[64 + s];
            end
            w[8*c +: 8] = ch;
        end
        return w;
    endfunction

    logic [71:0] exp_q[$];
    logic [71:0] m_out   = '0;
    logic        m_ready = 1'b0;
    logic        m_empty = 1'b1;
    logic        m_last  = 1'b0;
    logic        m_und   = 1'b0;
    int          m_cnt   = 0;

    always @(posedge clk or posedge rst) begin : model
        logic rd;
        logic wr;
        if (rst) begin
            exp_q.delete();
            m_out = '0; m_ready = 1'b0; m_empty = 1'b1;
            m_last = 1'b0; m_und = 1'b0; m_cnt = 0;
        end else begin
            rd = tx_en && (exp_q.size() != 0) && !m_empty;
            wr = in_valid && m_ready;
            if (tx_en && m_empty && m_last) begin
                m_und = 1'b1;
                m_cnt++;
            end
            if (rd) begin
                m_out  = pack(exp_q[0]);
                m_last = exp_q[0][71];
                void'(exp_q.pop_front());
            end else begin
                m_out  = '0;
                m_last = 1'b0;
            end
            if (und_clr) begin
                m_und = 1'b0;
                m_cnt = 0;
            end
            if (wr) exp_q.push_back({frame_in, data_in});
            m_empty = (exp_q.size() == 0);
            m_ready = (exp_q.size() != DEPTH);
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("dout", dout, m_out);
        check("in_ready", 72'(in_ready), 72'(m_ready));
        check("fifo_empty", 72'(fifo_empty), 72'(m_empty));
        check("underrun", 72'(underrun), 72'(m_und));
        check("underrun_cnt", 72'(cnt), 72'((m_cnt > 255) ? 255 : m_cnt));
        check("underrun_cnt_w2", 72'(cnt2), 72'((m_cnt > 3) ? 3 : m_cnt));
        check("dout_w2", dout2, m_out);
    end

    // ---------------- drivers ----------------
    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic push(input logic [63:0] d, input logic [7:0] f);
        bit acc;
        acc      = 1'b0;
        data_in  = d;
        frame_in = f;
        in_valid = 1'b1;
        for (int k = 0; k < 20 && !acc; k++) begin
            acc = in_ready;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("push_accept", 72'(acc), 72'(1));
    endtask

    task automatic clear_underrun();
        und_clr = 1'b1;
        @(negedge clk);
        und_clr = 1'b0;
    endtask

    logic [63:0] bp_data [4];
    logic [7:0]  bp_frame [4];

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; tx_en = 1'b0; in_valid = 1'b0; und_clr = 1'b0;
        data_in = '0; frame_in = '0;
        repeat (3) @(negedge clk);
        check("rst_dout", dout, 72'h0);
        check("rst_ready", 72'(in_ready), 72'(0));
        check("rst_empty", 72'(fifo_empty), 72'(1));
        check("rst_underrun", 72'(underrun), 72'(0));
        check("rst_cnt", 72'(cnt), 72'(0));
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 72'(in_ready), 72'(1));

        // Transpose of a known word
        tx_en = 1'b1;
        push(64'h0706050403020100, 8'hFF);
        @(negedge clk);
        check("transpose", dout, 72'hFF00000000000F3355);
        @(negedge clk);
        check("idle_after_word", dout, 72'h0);
        clear_underrun();

        // Streaming, back-to-back
        for (int i = 0; i < 16; i++) begin
            check("stream_ready", 72'(in_ready), 72'(1));
            push(64'h9E3779B97F4A7C15 * 64'(i + 1),
                 8'(i * 23 + 5) & ((i == 15) ? 8'h7F : 8'hFF));
        end
        repeat (4) @(negedge clk);
        check("stream_no_underrun", 72'(underrun), 72'(0));

        // Backpressure
        tx_en = 1'b0;
        bp_data[0] = 64'hA0A1A2A3A4A5A6A7; bp_frame[0] = 8'h81;
        bp_data[1] = 64'h0123456789ABCDEF; bp_frame[1] = 8'h42;
        bp_data[2] = 64'hFFFF0000FFFF0000; bp_frame[2] = 8'h24;
        bp_data[3] = 64'h5555AAAA3333CCCC; bp_frame[3] = 8'h18;
        for (int i = 0; i < 4; i++) begin
            push(bp_data[i], bp_frame[i]);
            check("bp_ready", 72'(in_ready), 72'((i < 3) ? 1 : 0));
        end
        check("bp_not_empty", 72'(fifo_empty), 72'(0));
        check("bp_idle", dout, 72'h0);
        data_in = 64'hDEADBEEFDEADBEEF; frame_in = 8'hFF; in_valid = 1'b1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        tx_en = 1'b1;
        @(negedge clk);
        check("bp_ready_back", 72'(in_ready), 72'(1));
        check("bp_first_out", dout, pack({bp_frame[0], bp_data[0]}));
        repeat (6) @(negedge clk);

        // Underrun
        clear_underrun();
        push(64'h1122334455667788, 8'hFF);
        @(negedge clk);
        check("ur_not_yet", 72'(underrun), 72'(0));
        @(negedge clk);
        check("ur_set", 72'(underrun), 72'(1));
        check("ur_cnt1", 72'(cnt), 72'(1));
        @(negedge clk);
        check("ur_cnt_hold", 72'(cnt), 72'(1));
        clear_underrun();
        check("ur_clr_flag", 72'(underrun), 72'(0));
        check("ur_clr_cnt", 72'(cnt), 72'(0));
        push(64'h8877665544332211, 8'h0F);
        repeat (4) @(negedge clk);
        check("ur_closed_frame", 72'(underrun), 72'(0));
        check("ur_closed_cnt", 72'(cnt), 72'(0));

        // Saturation
        for (int e = 0; e < 5; e++) begin
            push(64'(e) * 64'h0101010101010101, 8'hFF);
            repeat (3) @(negedge clk);
        end
        check("sat_cnt_w2", 72'(cnt2), 72'(3));
        check("sat_cnt_w8", 72'(cnt), 72'(5));

        // Asynchronous reset mid-operation
        tx_en = 1'b0;
        push(64'h1111111111111111, 8'h80);
        push(64'h2222222222222222, 8'h80);
        push(64'h3333333333333333, 8'h80);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_dout", dout, 72'h0);
        check("arst_empty", 72'(fifo_empty), 72'(1));
        check("arst_ready", 72'(in_ready), 72'(0));
        @(negedge clk);
        rst = 1'b0;
        tx_en = 1'b1;
        @(negedge clk);
        check("arst_ready_back", 72'(in_ready), 72'(1));
        for (int i = 0; i < 6; i++) begin
            check("arst_no_stale", dout, 72'h0);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
